uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 23 ++
 rtl/uart_rx.sv | 119 +++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Bus bundle for uart_rx: serial line and frame configuration in, received word and status pulses out.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic [5:0]            Prescale;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;

    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP,
        input  P_DATA, data_valid, par_err, stp_err
    );

    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP,
        output P_DATA, data_valid, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver with optional parity; one-cycle status pulse at each frame end.
// Define UART_RX_MAJORITY_SAMPLE_EN for 3-sample majority voting around the bit centre.
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input logic     CLK,
    input logic     RST,
    uart_rx_if.slave bus
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state, state_next;
    logic [5:0]            edge_cnt;
    logic [5:0]            prescale_q;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  par_en_q, par_typ_q;
    logic                  par_flag, stp_flag;
    logic [5:0]            half;
    logic                  last_edge, last_bit;
    logic                  sample_stb, sample_bit, frame_end;

`ifdef UART_RX_MAJORITY_SAMPLE_EN
    logic [1:0] early;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            early <= '0;
        end else if (edge_cnt == half - 6'd1) begin
            early[0] <= bus.RX_IN;
        end else if (edge_cnt == half) begin
            early[1] <= bus.RX_IN;
        end
    end
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!bus.RX_IN) state_next = START;
            START: begin
                if (sample_stb && sample_bit) state_next = IDLE;
                else if (last_edge)           state_next = DATA;
            end
            DATA:    if (last_edge && last_bit) state_next = par_en_q ? PARITY : STOP;
            PARITY:  if (last_edge) state_next = STOP;
            STOP:    if (last_edge) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        half      = {1'b0, prescale_q[5:1]};
        last_edge = (edge_cnt == prescale_q - 6'd1);
        last_bit  = (bit_cnt == BW'(DATA_WIDTH - 1));
        frame_end = (state == STOP) && last_edge;
`ifdef UART_RX_MAJORITY_SAMPLE_EN
        // Third vote arrives live one edge after centre, so the decision lands at half+1.
        sample_stb = (state != IDLE) && (edge_cnt == half + 6'd1);
        sample_bit = (early[0] & early[1]) | (early[0] & bus.RX_IN) | (early[1] & bus.RX_IN);
`else
        sample_stb = (state != IDLE) && (edge_cnt == half);
        sample_bit = bus.RX_IN;
`endif
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt       <= '0;
            bit_cnt        <= '0;
            shift_reg      <= '0;
            prescale_q     <= '0;
            par_en_q       <= 1'b0;
            par_typ_q      <= 1'b0;
            par_flag       <= 1'b0;
            stp_flag       <= 1'b0;
            bus.P_DATA     <= '0;
            bus.data_valid <= 1'b0;
            bus.par_err    <= 1'b0;
            bus.stp_err    <= 1'b0;
        end else begin
            bus.data_valid <= frame_end && !par_flag && !stp_flag;
            bus.par_err    <= frame_end && par_flag;
            bus.stp_err    <= frame_end && stp_flag;
            if (frame_end && !par_flag && !stp_flag) bus.P_DATA <= shift_reg;

            if (state == IDLE) begin
                // The falling-edge cycle itself is edge 0 of the start bit.
                edge_cnt <= bus.RX_IN ? 6'd0 : 6'd1;
                bit_cnt  <= '0;
                if (!bus.RX_IN) begin
                    prescale_q <= bus.Prescale;
                    par_en_q   <= bus.PAR_EN;
                    par_typ_q  <= bus.PAR_TYP;
                    par_flag   <= 1'b0;
                    stp_flag   <= 1'b0;
                end
            end else begin
                edge_cnt <= (last_edge || state_next == IDLE) ? 6'd0 : edge_cnt + 6'd1;
                if (state == DATA && last_edge) bit_cnt <= bit_cnt + BW'(1);
                if (sample_stb) begin
                    case (state)
                        DATA:    shift_reg <= {sample_bit, shift_reg[DATA_WIDTH-1:1]};
                        PARITY:  par_flag  <= sample_bit ^ (^shift_reg) ^ par_typ_q;
                        STOP:    stp_flag  <= !sample_bit;
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule
